// File: rtl/kgp_boot_loader.sv
// Byte-stream boot loader for the MiniRISC core: collects a length-prefixed,
// XOR-checksummed image into 32-bit words, writes them to imem, then releases core reset.
module kgp_boot_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CAP   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [7:0]         acc_q, acc_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        shift_q, shift_d;
    logic               byte_ready_q, byte_ready_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               xfer;
    logic [15:0]        len_n;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        acc_d        = acc_q;
        word_cnt_d   = word_cnt_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        done_d       = done_q;
        error_d      = error_q;
        xfer         = byte_valid && byte_ready_q;
        len_n        = {len_q[15:8], byte_data};

        case (state_q)
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d   = {byte_data, len_q[7:0]};
                    acc_d   = acc_q ^ byte_data;
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_n;
                    acc_d = acc_q ^ byte_data;
                    if (32'(len_n) > CAP) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else if (len_n == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d    = ST_DATA;
                        word_cnt_d = '0;
                        byte_idx_d = 2'd0;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    acc_d      = acc_q ^ byte_data;
                    shift_d    = {shift_q[15:0], byte_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        imem_wdata_d = {shift_q, byte_data};
                        word_cnt_d   = word_cnt_q + CNT_W'(1);
                        // Last word: its write lands next cycle while CHECK waits
                        if ((17'(word_cnt_q) + 17'd1) == 17'(len_q)) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    if (byte_data == acc_q) begin
                        state_d    = ST_RUN;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_RUN, ST_ERROR: begin
            end
            default: begin
                state_d = ST_ERROR;
                error_d = 1'b1;
            end
        endcase

        byte_ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                       (state_d == ST_DATA)   || (state_d == ST_CHECK);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LEN_HI;
            len_q        <= '0;
            acc_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            acc_q        <= acc_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_kgp_boot_loader.sv
// Bench for kgp_boot_loader: frames built from a word list, expected writes and
// outcome derived from the frame rules, writes captured by a monitor.
module tb_kgp_boot_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;

    logic [7:0]  frame_q[$];
    logic [31:0] words_q[$];
    logic [39:0] exp_wr_q[$];
    logic [39:0] wr_q[$];
    bit          exp_err;
    bit          pre_core_rst;

    kgp_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
        if (rst === 1'b0) chk("done_error_exclusive", 64'(done & error), 64'd0);
    end

    // Frame from words_q with length field n; reference outcome from the frame rules
    task automatic make_frame(input int n, input bit bad_ck);
        logic [7:0] ck;
        logic [31:0] w;
        frame_q.delete();
        exp_wr_q.delete();
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        if (n > int'(CAP)) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = words_q[i];
            for (int b = 3; b >= 0; b--) frame_q.push_back(8'(w >> (8 * b)));
            exp_wr_q.push_back({8'(i), w});
        end
        ck = 8'h00;
        foreach (frame_q[i]) ck = ck ^ frame_q[i];
        if (bad_ck) ck = ck ^ 8'h01;
        frame_q.push_back(ck);
        exp_err = bad_ck;
    endtask

    task automatic send(input int nbytes, input bit gap);
        int idx = 0;
        int cyc = 0;
        bit xfer;
        while (idx < nbytes) begin
            @(negedge clk);
            if (gap && ($urandom_range(0, 1) == 0)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = frame_q[idx];
            end
            xfer = byte_valid && byte_ready;
            if (xfer && idx == nbytes - 1) pre_core_rst = core_rst;
            @(posedge clk);
            if (xfer) idx++;
            cyc++;
            if (cyc > 20000) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
    endtask

    task automatic check_outcome(input string tag);
        @(negedge clk);
        byte_valid = 1'b0;
        chk({tag, "_done"},       64'(done),       64'(!exp_err));
        chk({tag, "_error"},      64'(error),      64'(exp_err));
        chk({tag, "_core_rst"},   64'(core_rst),   64'(exp_err));
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "_wr_count"},   64'(wr_q.size()), 64'(exp_wr_q.size()));
        for (int i = 0; i < exp_wr_q.size() && i < wr_q.size(); i++)
            chk({tag, "_wr"}, 64'(wr_q[i]), 64'(exp_wr_q[i]));
    endtask

    task automatic run(input string tag, input int n, input bit bad_ck, input bit gap);
        do_reset();
        make_frame(n, bad_ck);
        send(frame_q.size(), gap);
        check_outcome(tag);
    endtask

    initial begin
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("rst_imem_we",    64'(imem_we),    64'd0);
        chk("rst_imem_addr",  64'(imem_addr),  64'd0);
        chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_core_rst",   64'(core_rst),   64'd1);
        chk("rst_done",       64'(done),       64'd0);
        chk("rst_error",      64'(error),      64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(byte_ready), 64'd1);

        words_q = '{32'h12345678, 32'h9ABCDEF0};
        run("good2", 2, 1'b0, 1'b0);
        chk("good2_ck_byte", 64'(frame_q[10]), 64'h02);
        chk("good2_core_rst_before", 64'(pre_core_rst), 64'd1);
        run("badck2", 2, 1'b1, 1'b0);
        run("n0", 0, 1'b0, 1'b0);

        // Oversize length: only the two header bytes are sent
        do_reset();
        make_frame(CAP + 1, 1'b0);
        send(2, 1'b0);
        check_outcome("n257");

        words_q.delete();
        for (int i = 0; i < int'(CAP); i++) words_q.push_back($urandom);
        run("n256", CAP, 1'b0, 1'b0);
        chk("n256_last_addr", 64'(imem_addr), 64'hFF);

        words_q = '{32'hA5A5_0001, 32'h0BAD_F00D, 32'hFFFF_0000};
        run("gap3", 3, 1'b0, 1'b1);

        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 8);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            run("rand", n, ($urandom_range(0, 2) == 0), 1'b1);
        end

        // Reset right after the first word of a 2-word load is written
        words_q = '{32'hCAFE_BABE, 32'h1357_9BDF};
        do_reset();
        make_frame(2, 1'b0);
        send(6, 1'b0);
        @(negedge clk);
        chk("mid_we",    64'(imem_we),    64'd1);
        chk("mid_addr",  64'(imem_addr),  64'd0);
        chk("mid_wdata", 64'(imem_wdata), 64'hCAFEBABE);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("mid_rst_imem_we",    64'(imem_we),    64'd0);
        chk("mid_rst_addr",       64'(imem_addr),  64'd0);
        chk("mid_rst_wdata",      64'(imem_wdata), 64'd0);
        chk("mid_rst_core_rst",   64'(core_rst),   64'd1);
        chk("mid_rst_done",       64'(done),       64'd0);
        chk("mid_rst_error",      64'(error),      64'd0);
        rst = 1'b0;
        wr_q.delete();
        send(frame_q.size(), 1'b0);
        check_outcome("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kgp_boot_loader.md
Name: kgp_boot_loader

Overview:
- Upstream loader for the MiniRISC core.
- Receives a byte stream carrying a program image (length header, instruction words, checksum) and assembles the bytes into 32-bit instruction words.
- Writes the words into instruction memory, then releases the core's reset.
- Holds the core in reset until a complete, checksum-valid image has been written; a bad image latches an error.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity is 2**ADDR_W words.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
byte_valid  input  1  byte_data holds a valid byte this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address of the current write
imem_wdata  output  32  instruction word being written
core_rst  output  1  reset to the MiniRISC core; high until a successful load
done  output  1  image loaded and verified; core running
error  output  1  image rejected (length overflow or checksum mismatch)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, error=0. State=LEN_HI; word count, byte index and checksum accumulator all cleared.
- byte_ready=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in RUN, ERROR and the reset cycle. Bytes offered while byte_ready=0 are ignored.
- Frame format:
  - Length N: 16 bits, high byte first.
  - Then N words of 4 bytes each, most-significant byte first.
  - Then 1 checksum byte.
  - Checksum = XOR of both length bytes and all data bytes; the image is valid when it equals the received checksum byte.
- LEN_HI: on transfer, store the high length byte, XOR it into the accumulator, go to LEN_LO.
- LEN_LO: on transfer, store the low byte and accumulate it, then branch:
  - N > 2**ADDR_W: go to ERROR.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA with word counter=0 and byte index=0.
- DATA: each transfer shifts the byte into the word shift register (first byte ends in bits 31:24) and is accumulated.
  - On the 4th byte of a word, in the following cycle: imem_we=1 for exactly one cycle, imem_addr=word counter, imem_wdata=assembled word.
  - The word counter then increments and the byte index wraps to 0.
  - byte_ready stays 1, so a byte arriving in the write cycle is accepted and starts the next word.
  - After the 4th byte of word N-1, go to CHECK; that word's write still occurs in the following cycle.
- CHECK: on transfer, compare the byte with the accumulator.
  - Equal: next cycle core_rst=0, done=1, state RUN.
  - Not equal: next cycle error=1, state ERROR, core_rst stays 1.
- RUN: terminal state. done=1 and core_rst=0 are held; the stream is ignored.
- ERROR: terminal state. error=1 and core_rst=1 are held; no further writes. Only rst exits.
- Address: imem_addr is never ≥ 2**ADDR_W. When N == 2**ADDR_W, the final write address is 2**ADDR_W-1; the word counter is ADDR_W+1 bits wide so it does not wrap.
- Reset mid-load: any state returns to reset values the next cycle, including core_rst=1. A pending imem_we is dropped. Partially written memory is not cleared.
- byte_valid deasserted mid-word: the byte index and shift register hold, with no timeout.
- done and error are never both 1.

Test Plan:
- Load N=2 with words 0x12345678, 0x9ABCDEF0 and checksum 0x02 (= 0x00^0x02^all data bytes); byte_valid held high. Expect: imem_we pulses at addr 0 with 0x12345678 and at addr 1 with 0x9ABCDEF0; one cycle after the checksum byte, core_rst 1→0 and done=1.
- Same image with checksum 0x03. Expect: both writes occur; then error=1, core_rst stays 1, done=0, byte_ready=0.
- N=0 with checksum 0x00. Expect: no imem_we; done=1, core_rst=0 one cycle after the checksum byte.
- ADDR_W=8, length bytes 0x01,0x01 (N=257). Expect: error=1 the cycle after the 2nd byte, no imem_we ever. Also length 0x0100 (N=256): writes end at addr 0xFF, then done.
- Random byte_valid gaps (50% duty) during a 3-word load. Expect: the same imem_we address/data sequence as gap-free, and done.
- Assert rst for one cycle after word 0 of a 2-word load has been written. Expect: all outputs at reset values; a full valid frame sent afterwards loads from addr 0 and reaches done.
